// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
package mult_seq_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    PP0,
    PP1,
    PP2,
    PP3,
    DONE
  } state_t;

  localparam int unsigned SHIFT_PP0 = 0;
  localparam int unsigned SHIFT_PP1 = 4;
  localparam int unsigned SHIFT_PP2 = 4;
  localparam int unsigned SHIFT_PP3 = 8;

  // Zero-extend a 4x4 partial product and align it for the given PP state.
  function automatic logic [PROD_W-1:0] pp_term(input state_t s,
                                                input logic [2*NIB_W-1:0] p);
    logic [PROD_W-1:0] ext;
    ext = PROD_W'(p);
    case (s)
      PP0:     pp_term = ext << SHIFT_PP0;
      PP1:     pp_term = ext << SHIFT_PP1;
      PP2:     pp_term = ext << SHIFT_PP2;
      PP3:     pp_term = ext << SHIFT_PP3;
      default: pp_term = '0;
    endcase
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_if.sv
// Request/result handshake bundle between a datapath and mult8_seq_ctrl.
interface mult8_seq_ctrl_if #(
  parameter int unsigned TAG_W = 2
);
  import mult_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_a;
  logic [OP_W-1:0]   in_b;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [PROD_W-1:0] out_product;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_product, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_product, out_tag
  );

endinterface

// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiply sequenced over four cycles of an external 4x4 multiplier;
// FSM, nibble operand mux and shifted accumulator in one registered block.
module mult8_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int unsigned TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  mult8_seq_ctrl_if.slave      bus,
  output logic [NIB_W-1:0]     mul_a,
  output logic [NIB_W-1:0]     mul_b,
  input  logic [2*NIB_W-1:0]   mul_p,
  output logic                 busy
);

  state_t            state;
  logic [PROD_W-1:0] acc;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic [TAG_W-1:0]  tag_q;
  logic              in_ready;
  logic              out_valid;
  logic [PROD_W-1:0] out_product;
  logic [TAG_W-1:0]  out_tag;

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_product = out_product;
  assign bus.out_tag     = out_tag;

  // mul_a/mul_b are loaded one edge early so they are valid throughout each PP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
      busy        <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q      <= bus.in_a;
            b_q      <= bus.in_b;
            tag_q    <= bus.in_tag;
            acc      <= '0;
            mul_a    <= bus.in_a[NIB_W-1:0];
            mul_b    <= bus.in_b[NIB_W-1:0];
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= PP0;
          end
        end
        PP0: begin
          acc   <= acc + pp_term(state, mul_p);
          mul_a <= a_q[OP_W-1:NIB_W];
          mul_b <= b_q[NIB_W-1:0];
          state <= PP1;
        end
        PP1: begin
          acc   <= acc + pp_term(state, mul_p);
          mul_a <= a_q[NIB_W-1:0];
          mul_b <= b_q[OP_W-1:NIB_W];
          state <= PP2;
        end
        PP2: begin
          acc   <= acc + pp_term(state, mul_p);
          mul_a <= a_q[OP_W-1:NIB_W];
          mul_b <= b_q[OP_W-1:NIB_W];
          state <= PP3;
        end
        PP3: begin
          acc         <= acc + pp_term(state, mul_p);
          out_product <= acc + pp_term(state, mul_p);
          out_tag     <= tag_q;
          out_valid   <= 1'b1;
          mul_a       <= '0;
          mul_b       <= '0;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          mul_a     <= '0;
          mul_b     <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Bench for mult8_seq_ctrl: directed scenarios plus a randomized scoreboard run.
module tb_mult8_seq_ctrl;

  localparam int unsigned TW = 2;
  localparam int N_RAND = 1000;
  localparam int BUDGET = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic [7:0] mul_p;
  logic       busy;

  int checks = 0;
  int errors = 0;

  mult8_seq_ctrl_if #(.TAG_W(TW)) bus ();

  mult8_seq_ctrl #(.TAG_W(TW)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy)
  );

  // Stand-in for the external combinational 4x4 multiplier.
  assign mul_p = {4'b0, mul_a} * {4'b0, mul_b};

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected nibble pair for partial-product step k (0..3).
  function automatic logic [7:0] exp_nib(input logic [7:0] a, input logic [7:0] b, input int k);
    logic [3:0] an;
    logic [3:0] bn;
    an = (k == 1 || k == 3) ? a[7:4] : a[3:0];
    bn = (k >= 2) ? b[7:4] : b[3:0];
    return {an, bn};
  endfunction

  // One complete request; holds out_ready low for stall cycles, optionally poking in_valid while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [TW-1:0] tag,
                        input int stall, input bit poke);
    logic [15:0] exp_p;
    exp_p = 16'(a) * 16'(b);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready got %b want 1", bus.in_ready);
    end
    bus.in_a = a; bus.in_b = b; bus.in_tag = tag; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mul_a, mul_b} !== exp_nib(a, b, k) || bus.in_ready !== 1'b0 || busy !== 1'b1 ||
          bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL pp%0d a=%h b=%h got mul=%h/%h rdy=%b busy=%b ov=%b want mul=%h", k, a, b,
                 mul_a, mul_b, bus.in_ready, busy, bus.out_valid, exp_nib(a, b, k));
      end
      tick();
    end
    for (int s = 0; s <= stall; s++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_product !== exp_p || bus.out_tag !== tag ||
          {mul_a, mul_b} !== 8'h00 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL done[%0d] got ov=%b prod=%h tag=%0d mul=%h/%h rdy=%b want prod=%h tag=%0d",
                 s, bus.out_valid, bus.out_product, bus.out_tag, mul_a, mul_b, bus.in_ready,
                 exp_p, tag);
      end
      if (s < stall) begin
        if (poke) begin
          bus.in_valid = 1'b1; bus.in_a = ~a; bus.in_b = ~b; bus.in_tag = ~tag;
        end
        tick();
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release got ov=%b rdy=%b busy=%b want 0/1/0", bus.out_valid, bus.in_ready, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_hold got busy=%b ov=%b want 0/0", busy, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_product !== 16'h0 ||
        bus.out_tag !== '0 || busy !== 1'b0 || mul_a !== 4'h0 || mul_b !== 4'h0) begin
      errors++;
      $display("FAIL reset got rdy=%b ov=%b prod=%h tag=%0d busy=%b mul=%h/%h", bus.in_ready,
               bus.out_valid, bus.out_product, bus.out_tag, busy, mul_a, mul_b);
    end
  endtask

  task automatic test_max();
    run_op(8'hFF, 8'hFF, 2'd3, 0, 1'b0);
  endtask

  task automatic test_nibble_order();
    run_op(8'h12, 8'h34, 2'd1, 0, 1'b0);
  endtask

  task automatic test_stall();
    run_op(8'h80, 8'h02, 2'd2, 10, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a1, b1, a2, b2;
    a1 = 8'h00; b1 = 8'hAB; a2 = 8'h0F; b2 = 8'h10;
    bus.out_ready = 1'b1;
    bus.in_a = a1; bus.in_b = b1; bus.in_tag = 2'd1; bus.in_valid = 1'b1;
    tick();
    bus.in_a = a2; bus.in_b = b2; bus.in_tag = 2'd2;
    for (int c = 1; c <= 6; c++) begin
      checks++;
      if (bus.in_ready !== (c == 6) || bus.out_valid !== (c == 5)) begin
        errors++;
        $display("FAIL b2b_hs c%0d got rdy=%b ov=%b", c, bus.in_ready, bus.out_valid);
      end
      if (c <= 4) begin
        checks++;
        if ({mul_a, mul_b} !== exp_nib(a1, b1, c - 1)) begin
          errors++; $display("FAIL b2b_mul1 c%0d got %h/%h want %h", c, mul_a, mul_b,
                             exp_nib(a1, b1, c - 1));
        end
      end
      if (c == 5) begin
        checks++;
        if (bus.out_product !== 16'h0000 || bus.out_tag !== 2'd1) begin
          errors++; $display("FAIL b2b_res1 got %h tag %0d want 0000 tag 1", bus.out_product,
                             bus.out_tag);
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int c = 7; c <= 11; c++) begin
      if (c <= 10) begin
        checks++;
        if ({mul_a, mul_b} !== exp_nib(a2, b2, c - 7) || bus.out_valid !== 1'b0) begin
          errors++; $display("FAIL b2b_mul2 c%0d got %h/%h ov=%b want %h", c, mul_a, mul_b,
                             bus.out_valid, exp_nib(a2, b2, c - 7));
        end
      end else begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_product !== 16'h00F0 || bus.out_tag !== 2'd2) begin
          errors++; $display("FAIL b2b_res2 got ov=%b %h tag %0d want 00F0 tag 2", bus.out_valid,
                             bus.out_product, bus.out_tag);
        end
      end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bus.in_a = 8'h12; bus.in_b = 8'h34; bus.in_tag = 2'd1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({mul_a, mul_b} !== 8'h23) begin
      errors++; $display("FAIL abort_pp2 got %h/%h want 2/3", mul_a, mul_b);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_product !== 16'h0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL abort got rdy=%b ov=%b prod=%h busy=%b want 1/0/0000/0", bus.in_ready,
               bus.out_valid, bus.out_product, busy);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL abort_ghost c%0d got ov=1 want 0", i);
      end
    end
    bus.out_ready = 1'b0;
    run_op(8'h03, 8'h05, 2'd0, 0, 1'b0);
  endtask

  typedef struct packed {
    logic [7:0]    a;
    logic [7:0]    b;
    logic [TW-1:0] tag;
  } req_t;

  task automatic test_random();
    req_t q[$];
    req_t r;
    int sent = 0, got = 0, cyc = 0;
    bit fire_in, fire_out, prev_valid = 0, prev_ready = 0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    while (got < N_RAND && cyc < BUDGET) begin
      if (!bus.in_valid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
        bus.in_a = 8'($urandom); bus.in_b = 8'($urandom); bus.in_tag = TW'($urandom);
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (prev_valid && !prev_ready) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++; $display("FAIL rand_drop cycle %0d out_valid fell without out_ready", cyc);
        end
      end
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (fire_out) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra got prod=%h with nothing outstanding", bus.out_product);
        end else begin
          r = q.pop_front();
          if (bus.out_product !== 16'(r.a) * 16'(r.b) || bus.out_tag !== r.tag) begin
            errors++;
            $display("FAIL rand_res #%0d got %h tag %0d want %h tag %0d", got, bus.out_product,
                     bus.out_tag, 16'(r.a) * 16'(r.b), r.tag);
          end
        end
        got++;
      end
      if (fire_in) begin
        r.a = bus.in_a; r.b = bus.in_b; r.tag = bus.in_tag;
        q.push_back(r);
        sent++;
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      tick();
      cyc++;
      if (fire_in) bus.in_valid = 1'b0;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (got != N_RAND || q.size() != 0) begin
      errors++; $display("FAIL rand_count got %0d results (%0d pending) want %0d", got, q.size(),
                         N_RAND);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_nibble_order();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
